// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: zero-latency round-robin arbiter with per-agent weighted bursts and hold lock
module weighted_rr_arbiter #(
    parameter int AGENTS_NUM   = 4,
    parameter int WEIGHT_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AGENTS_NUM-1:0]                requests_i,
    input  logic [AGENTS_NUM-1:0]                hold_i,
    input  logic [AGENTS_NUM*WEIGHT_WIDTH-1:0]   weights_i,
    output logic [AGENTS_NUM-1:0]                grants_o,
    output logic                                 grant_valid_o,
    output logic [$clog2(AGENTS_NUM)-1:0]        grant_id_o
);
    localparam int PTR_SIZE = $clog2(AGENTS_NUM);
    typedef enum logic {IDLE, GRANTED} state_t;
    state_t                  r_state, w_state_next;
    logic [PTR_SIZE-1:0]     r_owner, w_owner_next, r_hp, w_hp_next, w_pick, w_gid;
    logic [WEIGHT_WIDTH-1:0] r_credits, w_credits_next, w_wsel;
    logic [WEIGHT_WIDTH-1:0] w_weights [AGENTS_NUM];
    logic                    w_cont, w_found, w_valid;
    int                      w_idx;
    for (genvar g = 0; g < AGENTS_NUM; g++) begin : g_w
        assign w_weights[g] = weights_i[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    assign w_cont        = r_state == GRANTED && requests_i[r_owner] && (hold_i[r_owner] || r_credits != '0);
    assign w_gid         = w_cont ? r_owner : w_pick;
    assign w_valid       = w_cont || w_found;
    assign w_wsel        = w_weights[w_pick];
    assign grant_valid_o = w_valid;
    assign grant_id_o    = w_valid ? w_gid : '0;
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = AGENTS_NUM - 1; k >= 0; k--) begin
            w_idx = int'(r_hp) + k;
            w_idx = w_idx >= AGENTS_NUM ? w_idx - AGENTS_NUM : w_idx;
            if (requests_i[w_idx[PTR_SIZE-1:0]]) begin
                w_pick  = w_idx[PTR_SIZE-1:0];
                w_found = 1'b1;
            end
        end
    end
    always_comb begin
        grants_o = '0;
        if (w_valid) grants_o[w_gid] = 1'b1;
    end
    always_comb begin
        w_state_next   = r_state;
        w_owner_next   = r_owner;
        w_credits_next = r_credits;
        w_hp_next      = r_hp;
        if (w_cont) begin
            w_credits_next = r_credits == '0 ? '0 : r_credits - 1'b1;
        end else if (w_found) begin
            w_state_next   = GRANTED;
            w_owner_next   = w_pick;
            w_credits_next = w_wsel == '0 ? '0 : w_wsel - 1'b1;
            w_hp_next      = w_pick == PTR_SIZE'(AGENTS_NUM - 1) ? '0 : w_pick + PTR_SIZE'(1);
        end else begin
            w_state_next   = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_credits <= '0;
            r_hp      <= '0;
        end else begin
            r_state   <= w_state_next;
            r_owner   <= w_owner_next;
            r_credits <= w_credits_next;
            r_hp      <= w_hp_next;
        end
    end
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: scoreboard bench for 4- and 3-agent arbiters against a rule-level model
module tb_weighted_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, hold = '0;
    logic [11:0] w = '0;
    logic [3:0]  g4;
    logic        v4;
    logic [1:0]  id4;
    logic [2:0]  g3;
    logic        v3;
    logic [1:0]  id3;
    typedef struct {int e4; int e3; int l4; int l3;} item_t;
    item_t q[$];
    int ms[2], mo[2], mc[2], mh[2];
    int passed = 0, total = 0;
    localparam logic [11:0] W1 = 12'o1111;
    always #5 clk = ~clk;
    weighted_rr_arbiter #(.AGENTS_NUM(4), .WEIGHT_WIDTH(3)) u4 (
        .clk(clk), .rst(rst), .requests_i(req), .hold_i(hold), .weights_i(w),
        .grants_o(g4), .grant_valid_o(v4), .grant_id_o(id4));
    weighted_rr_arbiter #(.AGENTS_NUM(3), .WEIGHT_WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .requests_i(req[2:0]), .hold_i(hold[2:0]), .weights_i(w[8:0]),
        .grants_o(g3), .grant_valid_o(v3), .grant_id_o(id3));
    function automatic int step(int u, int n);
        int g = -1;
        int wt;
        if (rst) begin
            ms[u] = 0; mo[u] = 0; mc[u] = 0; mh[u] = 0;
        end
        if (ms[u] == 1 && req[mo[u]] && (hold[mo[u]] || mc[u] > 0)) begin
            g = mo[u];
            if (mc[u] > 0) mc[u] = mc[u] - 1;
        end else begin
            for (int k = 0; k < n; k++)
                if (g < 0 && req[(mh[u] + k) % n]) g = (mh[u] + k) % n;
            if (!rst) begin
                if (g >= 0) begin
                    wt = int'(w[g*3 +: 3]);
                    ms[u] = 1; mo[u] = g;
                    mc[u] = (wt == 0 ? 1 : wt) - 1;
                    mh[u] = (g + 1) % n;
                end else ms[u] = 0;
            end
        end
        return g;
    endfunction
    task automatic cyc(input logic [3:0] r, input logic [3:0] h, input logic [11:0] ww,
                       input logic rr, input int l4, input int l3);
        item_t it;
        @(posedge clk);
        #1;
        req = r; hold = h; w = ww; rst = rr;
        it.e4 = step(0, 4);
        it.e3 = step(1, 3);
        it.l4 = l4;
        it.l3 = l3;
        q.push_back(it);
    endtask
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    initial forever begin
        item_t it;
        @(negedge clk);
        if (q.size() != 0) begin
            it = q.pop_front();
            chk("grants4", int'(g4), it.e4 < 0 ? 0 : 1 << it.e4);
            chk("valid4", int'(v4), int'(it.e4 >= 0));
            chk("id4", int'(id4), it.e4 < 0 ? 0 : it.e4);
            chk("onehot4", int'($countones(g4) <= 1), 1);
            chk("cons4", int'(v4 ? (int'(g4) == (1 << id4)) : (g4 == 0 && id4 == 0)), 1);
            chk("grants3", int'(g3), it.e3 < 0 ? 0 : 1 << it.e3);
            chk("valid3", int'(v3), int'(it.e3 >= 0));
            chk("id3", int'(id3), it.e3 < 0 ? 0 : it.e3);
            chk("onehot3", int'($countones(g3) <= 1), 1);
            chk("cons3", int'(v3 ? (int'(g3) == (1 << id3)) : (g3 == 0 && id3 == 0)), 1);
            if (it.l4 >= 0) chk("directed4", int'(g4), it.l4);
            if (it.l3 >= 0) chk("directed3", int'(g3), it.l3);
        end
    end
    initial begin
        int sa[5] = '{1, 2, 4, 8, 1};
        int sb[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
        int sf[4] = '{1, 2, 4, 1};
        logic [11:0] rw;
        cyc(4'h0, 4'h0, W1, 1'b1, 0, 0);
        foreach (sa[i]) cyc(4'hf, 4'h0, W1, 1'b0, sa[i], -1);
        cyc(4'h0, 4'h0, 12'o0003, 1'b1, 0, 0);
        foreach (sb[i]) cyc(4'b0011, 4'h0, 12'o0003, 1'b0, sb[i], -1);
        cyc(4'h0, 4'h0, W1, 1'b1, 0, 0);
        cyc(4'b0100, 4'b0100, W1, 1'b0, 4, -1);
        repeat (4) cyc(4'hf, 4'b0100, W1, 1'b0, 4, -1);
        cyc(4'hf, 4'h0, W1, 1'b0, 8, -1);
        cyc(4'h0, 4'h0, 12'o1114, 1'b1, 0, 0);
        repeat (2) cyc(4'b1001, 4'h0, 12'o1114, 1'b0, 1, -1);
        cyc(4'b1000, 4'h0, 12'o1114, 1'b0, 8, -1);
        cyc(4'h0, 4'h0, 12'o1141, 1'b1, 0, 0);
        cyc(4'b0010, 4'h0, 12'o1141, 1'b0, 2, -1);
        cyc(4'hf, 4'h0, 12'o1141, 1'b0, 2, -1);
        cyc(4'hf, 4'h0, 12'o1141, 1'b1, 1, -1);
        cyc(4'hf, 4'h0, 12'o1141, 1'b0, 1, -1);
        cyc(4'h0, 4'h0, W1, 1'b1, 0, 0);
        foreach (sf[i]) cyc(4'b0111, 4'h0, W1, 1'b0, sf[i], sf[i]);
        rw = 12'($urandom);
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) rw = 12'($urandom);
            cyc(4'($urandom), $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0, rw,
                $urandom_range(0, 49) == 0, -1, -1);
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
